// File: rtl/core_pkg.sv
// Shared definitions for the writeback pipe: load funct3 encodings, FSM states and stage records.
package core_pkg;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;

   typedef enum logic {WB_IDLE, WB_WAIT} wb_state_t;

   // Full record for the M stage, which still needs the load alignment controls.
   typedef struct packed {
      logic        valid;
      logic        load;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [2:0]  funct3;
      logic [1:0]  addr_lo;
   } wb_stage_t;

   // Once data is final (W and R) only the destination and value travel on.
   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_result_t;

endpackage

// File: rtl/core_writeback_pipe_if.sv
// EX/bus inputs and forward/write outputs of the writeback pipe, grouped as one bundle.
interface core_writeback_pipe_if;
   logic        i_ex_valid;
   logic [4:0]  i_ex_rd;
   logic [31:0] i_ex_wdata;
   logic        i_ex_load;
   logic [2:0]  i_ex_funct3;
   logic [1:0]  i_ex_addr_lo;
   logic        i_bus_rvalid;
   logic [31:0] i_bus_rdata;
   logic        o_stall;
   logic        o_rd_latch;
   logic        o_fwd1;
   logic [4:0]  o_faddr1;
   logic [31:0] o_fdata1;
   logic        o_fwd2;
   logic [4:0]  o_faddr2;
   logic [31:0] o_fdata2;
   logic        o_we;
   logic [4:0]  o_waddr;
   logic [31:0] o_wdata;
   logic        o_load_timeout;

   modport master (
      output i_ex_valid, i_ex_rd, i_ex_wdata, i_ex_load, i_ex_funct3, i_ex_addr_lo,
      output i_bus_rvalid, i_bus_rdata,
      input  o_stall, o_rd_latch, o_fwd1, o_faddr1, o_fdata1, o_fwd2, o_faddr2, o_fdata2,
      input  o_we, o_waddr, o_wdata, o_load_timeout
   );

   modport slave (
      input  i_ex_valid, i_ex_rd, i_ex_wdata, i_ex_load, i_ex_funct3, i_ex_addr_lo,
      input  i_bus_rvalid, i_bus_rdata,
      output o_stall, o_rd_latch, o_fwd1, o_faddr1, o_fdata1, o_fwd2, o_faddr2, o_fdata2,
      output o_we, o_waddr, o_wdata, o_load_timeout
   );
endinterface

// File: rtl/core_load_align.sv
// Selects the addressed byte/halfword lane of a bus word and sign- or zero-extends it.
module core_load_align
   import core_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         default: byte_v = rdata[31:24];
      endcase
      half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         FUNCT3_LB:  result = {{24{byte_v[7]}}, byte_v};
         FUNCT3_LH:  result = {{16{half_v[15]}}, half_v};
         FUNCT3_LBU: result = {24'h0, byte_v};
         FUNCT3_LHU: result = {16'h0, half_v};
         default:    result = rdata;
      endcase
   end

endmodule

// File: rtl/core_writeback_pipe.sv
// Carries EX results through M/W/R registers to forward and write ports; stalls the front
// pipeline while a load in M waits for its bus response, with a timeout fallback.
module core_writeback_pipe
   import core_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   core_writeback_pipe_if.slave wb
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

   wb_state_t  state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   wb_stage_t  m_q, m_d;
   wb_result_t w_q, w_d;
   wb_result_t r_q, r_d;

   wb_stage_t  ex_stage;
   logic [31:0] load_data;
   logic        stall;
   logic        timeout;
   logic        fwd1;

   core_load_align u_align (
      .funct3  (m_q.funct3),
      .addr_lo (m_q.addr_lo),
      .rdata   (wb.i_bus_rdata),
      .result  (load_data)
   );

   // A load to x0 is still tracked (load=1) so it stalls, but it never becomes a valid write.
   always_comb begin
      ex_stage = '0;
      if (wb.i_ex_valid) begin
         ex_stage.valid   = (wb.i_ex_rd != 5'd0);
         ex_stage.load    = wb.i_ex_load;
         ex_stage.rd      = wb.i_ex_rd;
         ex_stage.data    = (wb.i_ex_load || wb.i_ex_rd == 5'd0) ? 32'h0 : wb.i_ex_wdata;
         ex_stage.funct3  = wb.i_ex_funct3;
         ex_stage.addr_lo = wb.i_ex_addr_lo;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      m_d     = m_q;
      w_d     = w_q;
      r_d     = w_q;
      stall   = 1'b0;
      timeout = 1'b0;
      if (state_q == WB_IDLE) begin
         m_d     = ex_stage;
         w_d     = '{valid: m_q.valid, rd: m_q.rd, data: m_q.data};
         cnt_d   = 8'd0;
         state_d = ex_stage.load ? WB_WAIT : WB_IDLE;
      end else if (wb.i_bus_rvalid || cnt_q >= CNT_LAST) begin
         // Response (or timeout) retires the oldest load and lets EX advance in the same cycle.
         timeout = ~wb.i_bus_rvalid;
         m_d     = ex_stage;
         w_d     = '{valid: m_q.valid, rd: m_q.rd,
                     data: (wb.i_bus_rvalid && m_q.valid) ? load_data : 32'h0};
         cnt_d   = 8'd0;
         state_d = ex_stage.load ? WB_WAIT : WB_IDLE;
      end else begin
         stall = 1'b1;
         w_d   = '0;
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WB_IDLE;
         cnt_q   <= 8'd0;
         m_q     <= '0;
         w_q     <= '0;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         m_q     <= m_d;
         w_q     <= w_d;
         r_q     <= r_d;
      end
   end

   assign fwd1              = m_q.valid & ~m_q.load;
   assign wb.o_stall        = stall;
   assign wb.o_rd_latch     = stall;
   assign wb.o_load_timeout = timeout;
   assign wb.o_fwd1         = fwd1;
   assign wb.o_faddr1       = fwd1 ? m_q.rd : 5'd0;
   assign wb.o_fdata1       = fwd1 ? m_q.data : 32'h0;
   assign wb.o_fwd2         = w_q.valid;
   assign wb.o_faddr2       = w_q.valid ? w_q.rd : 5'd0;
   assign wb.o_fdata2       = w_q.valid ? w_q.data : 32'h0;
   assign wb.o_we           = r_q.valid;
   assign wb.o_waddr        = r_q.valid ? r_q.rd : 5'd0;
   assign wb.o_wdata        = r_q.valid ? r_q.data : 32'h0;

endmodule
